// File: rtl/instr_perf_pkg.sv
// Shared definitions for the instruction performance-counter controller:
// RV32 opcodes, class enumeration and the opcode-to-class mapping.
package instr_perf_pkg;

  localparam int NUM_CLS = 10;
  localparam int IDX_W   = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [IDX_W-1:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_STORE  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_OTHER  = 4'd9
  } cls_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  function automatic cls_e cls_of(input logic [6:0] opcode);
    cls_e c;
    case (opcode)
      OP_R:      c = CLS_R;
      OP_IALU:   c = CLS_IALU;
      OP_STORE:  c = CLS_STORE;
      OP_LOAD:   c = CLS_LOAD;
      OP_BRANCH: c = CLS_BRANCH;
      OP_LUI:    c = CLS_LUI;
      OP_AUIPC:  c = CLS_AUIPC;
      OP_JAL:    c = CLS_JAL;
      OP_JALR:   c = CLS_JALR;
      default:   c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: exactly one bit of o_onehot is set.
module instr_class_decode
  import instr_perf_pkg::*;
(
  input  logic [6:0]         i_opcode,
  output logic [NUM_CLS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    o_onehot[int'(cls_of(i_opcode))] = 1'b1;
  end

endmodule

// File: rtl/instr_perf_ctrl.sv
// Per-class saturating retire counters with snapshot-and-stream readout
// over a valid/ready port.
module instr_perf_ctrl
  import instr_perf_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ctrlf,
  input  logic               cnt_en,
  input  logic               clear,
  input  logic               dump_req,
  input  logic               dump_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [CNT_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  logic [NUM_CLS-1:0] w_hit;
  logic [NUM_CLS-1:0] w_inc;
  logic               w_event;
  logic               w_accept;
  logic               w_hs;
  logic               w_unused_instr;

  logic [CNT_W-1:0]   r_cnt      [NUM_CLS];
  logic [NUM_CLS-1:0] r_ovf;
  logic [CNT_W-1:0]   r_snap_cnt [NUM_CLS];
  logic [NUM_CLS-1:0] r_snap_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic               r_done;
  state_e             r_state;
  state_e             w_state_nxt;

  assign w_unused_instr = ^instr[INSTR_W-1:7];

  instr_class_decode u_decode (
    .i_opcode (instr[6:0]),
    .o_onehot (w_hit)
  );

  assign w_event  = instr_valid & ~ctrlf & cnt_en;
  assign w_inc    = w_event ? w_hit : '0;
  assign w_accept = (r_state == ST_IDLE) & dump_req;

  assign out_valid = (r_state == ST_SEND);
  assign busy      = (r_state != ST_IDLE);
  assign out_idx   = r_idx;
  assign out_data  = r_snap_cnt[r_idx];
  assign out_ovf   = r_snap_ovf[r_idx];
  assign out_last  = (r_idx == IDX_W'(NUM_CLS - 1));
  assign done      = r_done;
  assign w_hs      = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (dump_req)            w_state_nxt = ST_SEND;
      ST_SEND: if (out_ready & out_last) w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_hs & out_last;
      if (w_accept)  r_idx <= '0;
      else if (w_hs) r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Snapshot takes pre-edge values; dump_clr restarts each counter at the
  // same-cycle event so nothing is lost or double-counted across the dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) begin
        r_cnt[i]      <= '0;
        r_snap_cnt[i] <= '0;
      end
      r_ovf      <= '0;
      r_snap_ovf <= '0;
    end else begin
      if (w_accept) begin
        for (int unsigned i = 0; i < NUM_CLS; i++) r_snap_cnt[i] <= r_cnt[i];
        r_snap_ovf <= r_ovf;
      end
      for (int unsigned i = 0; i < NUM_CLS; i++) begin
        if (clear) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_accept & dump_clr) begin
          r_cnt[i] <= CNT_W'(w_inc[i]);
          r_ovf[i] <= 1'b0;
        end else if (w_inc[i]) begin
          if (r_cnt[i] == '1) r_ovf[i] <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_perf_ctrl.sv
// Scoreboard bench: a reference model predicts each readout beat when the
// dump is accepted; a monitor pops and compares beats as they handshake.
module tb_instr_perf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ctrlf;
  logic        cnt_en;
  logic        clear;
  logic        dump_req;
  logic        dump_clr;
  logic        out_ready;

  logic        m_valid, m_ovf, m_last, m_busy, m_done;
  logic [3:0]  m_idx;
  logic [16:0] m_data;
  logic        s_valid, s_ovf, s_last, s_busy, s_done;
  logic [3:0]  s_idx;
  logic [1:0]  s_data;

  instr_perf_ctrl #(.INSTR_W(32), .CNT_W(17)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .ctrlf(ctrlf), .cnt_en(cnt_en), .clear(clear), .dump_req(dump_req),
    .dump_clr(dump_clr), .out_valid(m_valid), .out_ready(out_ready),
    .out_idx(m_idx), .out_data(m_data), .out_ovf(m_ovf), .out_last(m_last),
    .busy(m_busy), .done(m_done)
  );

  instr_perf_ctrl #(.INSTR_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .ctrlf(ctrlf), .cnt_en(cnt_en), .clear(clear), .dump_req(dump_req),
    .dump_clr(dump_clr), .out_valid(s_valid), .out_ready(out_ready),
    .out_idx(s_idx), .out_data(s_data), .out_ovf(s_ovf), .out_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  // sel=1 routes the narrow-counter instance to the monitor
  bit          sel;
  logic        mon_valid, mon_ovf, mon_last, mon_busy, mon_done;
  logic [3:0]  mon_idx;
  logic [16:0] mon_data;
  assign mon_valid = sel ? s_valid : m_valid;
  assign mon_ovf   = sel ? s_ovf   : m_ovf;
  assign mon_last  = sel ? s_last  : m_last;
  assign mon_busy  = sel ? s_busy  : m_busy;
  assign mon_done  = sel ? s_done  : m_done;
  assign mon_idx   = sel ? s_idx   : m_idx;
  assign mon_data  = sel ? {15'b0, s_data} : m_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic [16:0] data;
    logic        ovf;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  int unsigned mcnt [2][10];
  bit          movf [2][10];
  int unsigned mmax [2] = '{32'd131071, 32'd3};
  int          beats_left = 0;
  bit          done_m = 0;

  function automatic int cls_ref(input logic [6:0] op);
    case (op)
      7'h33: return 0;
      7'h13: return 1;
      7'h23: return 2;
      7'h03: return 3;
      7'h63: return 4;
      7'h37: return 5;
      7'h17: return 6;
      7'h6F: return 7;
      7'h67: return 8;
      default: return 9;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 10; c++) begin
        mcnt[d][c] = 0;
        movf[d][c] = 0;
      end
    beats_left = 0;
    done_m = 0;
    exp_q.delete();
  endtask

  task automatic cyc();
    bit ev, acc, hs;
    int c;
    @(posedge clk);
    if (rst_n) begin
      ev  = instr_valid && !ctrlf && cnt_en;
      c   = cls_ref(instr[6:0]);
      acc = (beats_left == 0) && dump_req;
      hs  = (beats_left > 0) && out_ready;
      done_m = hs && (beats_left == 1);
      if (acc) begin
        for (int b = 0; b < 10; b++)
          exp_q.push_back('{idx: 4'(b), data: 17'(mcnt[sel][b]), ovf: movf[sel][b], last: (b == 9)});
        beats_left = 10;
      end else if (hs) begin
        beats_left--;
      end
      for (int d = 0; d < 2; d++) begin
        if (clear) begin
          for (int k = 0; k < 10; k++) begin mcnt[d][k] = 0; movf[d][k] = 0; end
        end else if (acc && dump_clr) begin
          for (int k = 0; k < 10; k++) begin mcnt[d][k] = 0; movf[d][k] = 0; end
          if (ev) mcnt[d][c] = 1;
        end else if (ev) begin
          if (mcnt[d][c] == mmax[d]) movf[d][c] = 1;
          else mcnt[d][c]++;
        end
      end
    end
    #1;
  endtask

  task automatic retire(input logic [6:0] op, input bit fl, input bit en);
    instr_valid = 1;
    instr = $urandom();
    instr[6:0] = op;
    ctrlf = fl;
    cnt_en = en;
    cyc();
    instr_valid = 0;
    ctrlf = 0;
    cnt_en = 1;
  endtask

  task automatic dump(input bit clr);
    dump_req = 1;
    dump_clr = clr;
    cyc();
    dump_req = 0;
    dump_clr = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    cyc();
    clear = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1;
    while (beats_left > 0 && n < 100) begin
      cyc();
      n++;
    end
    if (beats_left > 0) chk({tag, "_timeout"}, 32'd1, 32'd0);
    cyc();
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: protocol, busy/done and stall-stability checks plus beat scoreboard
  bit          stalled_prev = 0;
  logic [3:0]  prev_idx;
  logic [16:0] prev_data;
  logic        prev_ovf;
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      chk("valid", mon_valid, beats_left != 0);
      chk("busy", mon_busy, beats_left != 0);
      chk("done", mon_done, done_m);
      if (mon_valid && stalled_prev) begin
        chk("stall_idx", mon_idx, prev_idx);
        chk("stall_data", mon_data, prev_data);
        chk("stall_ovf", mon_ovf, prev_ovf);
      end
      if (mon_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", mon_idx, e.idx);
          chk("beat_data", mon_data, e.data);
          chk("beat_ovf", mon_ovf, e.ovf);
          chk("beat_last", mon_last, e.last);
        end
      end
      stalled_prev = mon_valid && !out_ready;
      prev_idx  = mon_idx;
      prev_data = mon_data;
      prev_ovf  = mon_ovf;
    end else begin
      stalled_prev = 0;
    end
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    sel = 0;
    rst_n = 0; instr_valid = 0; instr = '0; ctrlf = 0; cnt_en = 1;
    clear = 0; dump_req = 0; dump_clr = 0; out_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_data", m_data, 0);
    chk("rst_idx", m_idx, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ovf", m_ovf, 0);
    rst_n = 1;
    cyc();

    // 1: one of each class, then full-rate dump
    for (int i = 0; i < 10; i++) retire(ops[i], 0, 1);
    out_ready = 1;
    dump(0);
    chk("t1_first_beat_latency", m_valid, 1);
    chk("t1_first_beat_data", m_data, 1);
    drain("t1");

    // 2: flushed or disabled retires are not counted
    pulse_clear();
    for (int i = 0; i < 10; i++) retire(ops[i], 1, 1);
    for (int i = 0; i < 10; i++) retire(ops[i], 0, 0);
    dump(0);
    drain("t2");

    // 3: saturation on the 2-bit build, then clear
    sel = 1;
    pulse_clear();
    for (int i = 0; i < 4; i++) retire(7'h33, 0, 1);
    dump(0);
    chk("t3_sat_data", s_data, 3);
    chk("t3_sat_ovf", s_ovf, 1);
    drain("t3a");
    pulse_clear();
    dump(0);
    drain("t3b");
    sel = 0;

    // 4: dump_clr coinciding with a LOAD retire
    pulse_clear();
    for (int i = 0; i < 5; i++) retire(7'h03, 0, 1);
    instr_valid = 1; instr = 32'h0000_0003; dump_req = 1; dump_clr = 1;
    cyc();
    instr_valid = 0; dump_req = 0; dump_clr = 0;
    drain("t4a");
    dump(0);
    drain("t4b");

    // 5: back-pressure, counting during SEND, ignored dump_req while busy
    pulse_clear();
    for (int i = 0; i < 12; i++) retire(ops[$urandom_range(0, 9)], 0, 1);
    out_ready = 0;
    dump(0);
    for (int k = 0; k < 100 && beats_left > 0; k++) begin
      out_ready = (k % 3 == 2);
      dump_req = (k == 4);
      instr_valid = $urandom_range(0, 1);
      instr = $urandom();
      instr[6:0] = ops[$urandom_range(0, 9)];
      chk("t5_busy", m_busy, 1);
      cyc();
    end
    dump_req = 0; instr_valid = 0;
    drain("t5a");
    dump(0);
    drain("t5b");

    // 6: reset in the middle of a readout
    pulse_clear();
    for (int i = 0; i < 10; i++) retire(ops[i], 0, 1);
    out_ready = 1;
    dump(0);
    for (int k = 0; k < 20 && beats_left > 6; k++) cyc();
    rst_n = 0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_busy", m_busy, 0);
    model_reset();
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    dump(0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
